// File: rtl/i2c_data_unit_pkg.sv
// Shared constants for the I2C data unit: default byte width and the named
// control levels used by the controller and the datapath.
package i2c_data_unit_pkg;

    localparam int   LENGTH_DEFAULT = 8;

    localparam logic READ     = 1'b0;
    localparam logic WRITE    = 1'b1;
    localparam logic SEL_DATA = 1'b1;
    localparam logic SEL_CTRL = 1'b0;
    localparam logic SHIFT    = 1'b1;
    localparam logic HOLD     = 1'b0;

endpackage

// File: rtl/i2c_shift_reg.sv
// Parallel-load / shift-left register: synchronous clear beats load, and load
// beats shift. Bits shift MSB-first and the bit leaving the top is dropped.
module i2c_shift_reg
    import i2c_data_unit_pkg::*;
#(
    parameter int WIDTH = LENGTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift != HOLD) begin
            q <= {q[WIDTH-2:0], serial_in};
        end
    end

endmodule

// File: rtl/i2c_data_unit.sv
// I2C byte datapath: shift register plus the open-drain SDA driver. SDA is only
// ever pulled low or released; the bus pull-up supplies the high level.
module i2c_data_unit
    import i2c_data_unit_pkg::*;
#(
    parameter int LENGTH = LENGTH_DEFAULT
) (
    input  logic              Reset,
    input  logic              clock,
    input  logic              WriteLoad,
    input  logic              ReadorWrite,
    input  logic              ShiftorHold,
    input  logic              Select,
    input  logic              StartStopAck,
    input  logic [LENGTH-1:0] SentData,
    output logic [LENGTH-1:0] ReceivedData,
    inout  wire               SDA
);

    logic [LENGTH-1:0] sr;
    logic              out_bit;
    logic              drive_low;
    logic              sda_level;

    // A released line resolves to 1 through the external pull-up.
    assign sda_level = SDA;

    i2c_shift_reg #(
        .WIDTH(LENGTH)
    ) u_shift_reg (
        .clk       (clock),
        .rst       (Reset),
        .load      (WriteLoad),
        .shift     (ShiftorHold),
        .din       (SentData),
        .serial_in (sda_level),
        .q         (sr)
    );

    assign out_bit   = (Select == SEL_DATA) ? sr[LENGTH-1] : StartStopAck;
    assign drive_low = (ReadorWrite == WRITE) && !out_bit;
    assign SDA       = drive_low ? 1'b0 : 1'bz;

    assign ReceivedData = sr;

endmodule

// File: tb/tb_i2c_data_unit.sv
// Bench for i2c_data_unit: SDA with a pull-up and an open-drain external
// driver, a reference model of the shift register, and an expected-value queue.
module tb_i2c_data_unit;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         wl;
    logic         rw;
    logic         sh;
    logic         sel;
    logic         ssa;
    logic [W-1:0] sent;
    logic [W-1:0] rd;
    logic         ext_low;
    wire          sda;

    int errors;
    int checks;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_sr;

    pullup pu_sda (sda);
    assign sda = ext_low ? 1'b0 : 1'bz;

    i2c_data_unit #(
        .LENGTH(W)
    ) dut (
        .Reset        (rst),
        .clock        (clk),
        .WriteLoad    (wl),
        .ReadorWrite  (rw),
        .ShiftorHold  (sh),
        .Select       (sel),
        .StartStopAck (ssa),
        .SentData     (sent),
        .ReceivedData (rd),
        .SDA          (sda)
    );

    // clock / reset
    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check SDA before the rising
    // edge, then check the register after it. exp_sda < 0 uses the model level.
    task automatic cycle(input string tag, input logic r, input logic l, input logic m,
                         input logic s, input logic sl, input logic a,
                         input logic [W-1:0] d, input logic xl, input int exp_sda);
        logic dut_low;
        logic level;
        @(negedge clk);
        rst = r; wl = l; rw = m; sh = s; sel = sl; ssa = a; sent = d; ext_low = xl;
        #1;
        dut_low = m && !(sl ? model_sr[W-1] : a);
        level   = !(dut_low || xl);
        if (exp_sda < 0) exp_q.push_back({{(W-1){1'b0}}, level});
        else             exp_q.push_back({{(W-1){1'b0}}, exp_sda[0]});
        check_eq({tag, "_sda"}, {{(W-1){1'b0}}, sda}, exp_q.pop_front());
        if (r)      model_sr = '0;
        else if (l) model_sr = d;
        else if (s) model_sr = {model_sr[W-2:0], level};
        exp_q.push_back(model_sr);
        @(posedge clk);
        #1;
        check_eq({tag, "_rd"}, rd, exp_q.pop_front());
    endtask

    initial begin
        logic [W-1:0] pat;
        logic [W-1:0] held;
        errors = 0;
        checks = 0;
        model_sr = '0;
        rst = 1'b1; wl = 1'b0; rw = 1'b0; sh = 1'b0; sel = 1'b0; ssa = 1'b1;
        sent = '0; ext_low = 1'b0;

        // Reset overrides a simultaneous load for two edges.
        cycle("rst0", 1, 1, 0, 0, 1, 1, 8'hCA, 0, -1);
        cycle("rst1", 1, 1, 0, 1, 1, 1, 8'hCA, 0, -1);
        check_eq("rst_value", rd, 8'h00);

        // Transmit 0xCA MSB first; SDA is sampled before each shift.
        cycle("load_ca", 0, 1, 0, 0, 1, 1, 8'hCA, 0, -1);
        check_eq("load_ca_value", rd, 8'hCA);
        pat = 8'hCA;
        for (int i = 0; i < W; i++)
            cycle("tx_bit", 0, 0, 1, 1, 1, 1, 8'h00, 0, int'(pat[W-1-i]));

        // Receive 0xA5 from an external open-drain driver. SR is cleared first
        // so a wrongly enabled DUT driver would pull the line low.
        cycle("load_00", 0, 1, 0, 0, 1, 1, 8'h00, 0, -1);
        pat = 8'hA5;
        for (int i = 0; i < W; i++)
            cycle("rx_bit", 0, 0, 0, 1, 1, 1, 8'h00, !pat[W-1-i], int'(pat[W-1-i]));
        check_eq("rx_value", rd, 8'hA5);

        // ACK / control level path, register held.
        cycle("ack_low",  0, 0, 1, 0, 0, 0, 8'h00, 0, 0);
        cycle("ack_high", 0, 0, 1, 0, 0, 1, 8'h00, 0, 1);
        cycle("ack_rel",  0, 0, 0, 0, 0, 0, 8'h00, 0, 1);
        check_eq("ack_hold", rd, 8'hA5);

        // Load wins over shift; then hold for five cycles.
        cycle("load_3c", 0, 1, 0, 0, 1, 1, 8'h3C, 0, -1);
        cycle("load_pri", 0, 1, 1, 1, 1, 1, 8'h96, 0, -1);
        check_eq("load_pri_value", rd, 8'h96);
        held = rd;
        for (int i = 0; i < 5; i++)
            cycle("hold", 0, 0, i[0], 0, i[1], i[2], 8'(i * 37), 0, -1);
        check_eq("hold_value", rd, 8'h96);

        // Mid-byte reset aborts the transfer.
        cycle("mid_load", 0, 1, 0, 0, 1, 1, 8'hF3, 0, -1);
        for (int i = 0; i < 3; i++)
            cycle("mid_shift", 0, 0, 1, 1, 1, 1, 8'h00, 0, -1);
        cycle("mid_rst", 1, 0, 0, 1, 1, 1, 8'hFF, 0, -1);
        check_eq("mid_rst_value", rd, 8'h00);

        // Random traffic against the model.
        for (int i = 0; i < 60; i++)
            cycle("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
